// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I pipeline sequencer for load-use stalls, mispredict flushes and memory-wait freeze
// Ports: CLK/RST (sync, active-high); rs1D/rs2D/use_rs1D/use_rs2D describe the D instruction;
//   rdE/mem_loadE/reg_writeE/fail_predictE describe the E instruction; mem_reqM/mem_ready describe M.
//   Outputs: stall (D/E bubble), hold_fd (hold PC and F-D), flush_fd (zero F-D), freeze (hold all),
//   mem_err (sticky memory-wait timeout), ldstl (debug: multi-cycle stall in progress).
// Define HAZ_PERF_EN to add PERF_W-wide perf_stall/perf_flush/perf_freeze cycle counters.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int MEM_TO   = 16
`ifdef HAZ_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic       use_rs1D,
  input  logic       use_rs2D,
  input  logic [4:0] rdE,
  input  logic [2:0] mem_loadE,
  input  logic       reg_writeE,
  input  logic       fail_predictE,
  input  logic       mem_reqM,
  input  logic       mem_ready,
  output logic       stall,
  output logic       hold_fd,
  output logic       flush_fd,
  output logic       freeze,
  output logic       mem_err,
  output logic       ldstl
`ifdef HAZ_PERF_EN
  , output logic [PERF_W-1:0] perf_stall
  , output logic [PERF_W-1:0] perf_flush
  , output logic [PERF_W-1:0] perf_freeze
`endif
);
  typedef enum logic {RUN, LDSTL} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       luh, memwait, st, fl, fr;
  assign luh = reg_writeE & |mem_loadE & (rdE != 5'd0) &
               ((use_rs1D & (rs1D == rdE)) | (use_rs2D & (rs2D == rdE)));
  assign memwait = mem_reqM & ~mem_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st      = 1'b0;
    fl      = 1'b0;
    fr      = 1'b0;
    if (memwait) begin
      fr = 1'b1;
      st = state_q == LDSTL;
    end else if (state_q == LDSTL) begin
      if (fail_predictE) begin
        fl      = 1'b1;
        cnt_d   = 3'd0;
        state_d = RUN;
      end else begin
        st      = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? RUN : LDSTL;
      end
    end else if (fail_predictE) begin
      fl = 1'b1;
    end else if (luh) begin
      st = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = LDSTL;
        cnt_d   = 3'(LOAD_LAT - 1);
      end
    end
  end
  // wcnt counts consecutive freeze cycles and saturates instead of wrapping
  assign wcnt_d = fr ? (wcnt_q == 8'hff ? wcnt_q : wcnt_q + 8'd1) : 8'd0;
  assign err_d  = err_q | (fr & (wcnt_q == 8'(MEM_TO - 1)));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end
  assign stall    = st & ~RST;
  assign hold_fd  = st & ~RST;
  assign flush_fd = fl & ~RST;
  assign freeze   = fr & ~RST;
  assign mem_err  = err_q & ~RST;
  assign ldstl    = (state_q == LDSTL) & ~RST;
`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] ps_q, pf_q, pz_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_q <= '0;
      pf_q <= '0;
      pz_q <= '0;
    end else begin
      ps_q <= ps_q + PERF_W'(stall);
      pf_q <= pf_q + PERF_W'(flush_fd);
      pz_q <= pz_q + PERF_W'(freeze);
    end
  end
  assign perf_stall  = ps_q;
  assign perf_flush  = pf_q;
  assign perf_freeze = pz_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized check of hazard_ctrl (LOAD_LAT=3/MEM_TO=16 and LOAD_LAT=1/MEM_TO=4) against a bubble-debt model
module tb_hazard_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] rs1D, rs2D, rdE;
  logic       use_rs1D, use_rs2D, reg_writeE, fail_predictE, mem_reqM, mem_ready;
  logic [2:0] mem_loadE;
  wire  [11:0] ob;
  wire  [191:0] pb;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always #5 CLK = ~CLK;
  hazard_ctrl #(.LOAD_LAT(3), .MEM_TO(16)) u_l3 (
    .CLK(CLK), .RST(RST), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE), .fail_predictE(fail_predictE),
    .mem_reqM(mem_reqM), .mem_ready(mem_ready),
    .stall(ob[5]), .hold_fd(ob[4]), .flush_fd(ob[3]), .freeze(ob[2]), .mem_err(ob[1]), .ldstl(ob[0])
`ifdef HAZ_PERF_EN
    , .perf_stall(pb[31:0]), .perf_flush(pb[63:32]), .perf_freeze(pb[95:64])
`endif
  );
  hazard_ctrl #(.LOAD_LAT(1), .MEM_TO(4)) u_l1 (
    .CLK(CLK), .RST(RST), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE), .fail_predictE(fail_predictE),
    .mem_reqM(mem_reqM), .mem_ready(mem_ready),
    .stall(ob[11]), .hold_fd(ob[10]), .flush_fd(ob[9]), .freeze(ob[8]), .mem_err(ob[7]), .ldstl(ob[6])
`ifdef HAZ_PERF_EN
    , .perf_stall(pb[127:96]), .perf_flush(pb[159:128]), .perf_freeze(pb[191:160])
`endif
  );
`ifndef HAZ_PERF_EN
  assign pb = '0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  // Model: each instance owes a number of remaining bubble cycles; a hazard creates LOAD_LAT of them.
  int          lat [2] = '{3, 1};
  int          tmo [2] = '{16, 4};
  int          owed [2];
  int          frz_run [2];
  bit          err [2];
  logic [31:0] pc [2][3];
  initial begin
    int busy_left = 0;
    bit luh, mw, e_st, e_fl, e_fr;
    for (int i = 0; i < 2; i++) begin
      owed[i] = 0; frz_run[i] = 0; err[i] = 0;
      for (int k = 0; k < 3; k++) pc[i][k] = 0;
    end
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      RST = (cyc < 2) || ($urandom_range(0, 79) == 0);
      if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 22);
      if (busy_left > 0) begin
        mem_reqM = 1'b1; mem_ready = 1'b0; busy_left--;
      end else begin
        mem_reqM = 1'($urandom_range(0, 1)); mem_ready = $urandom_range(0, 3) != 0;
      end
      fail_predictE = $urandom_range(0, 9) == 0;
      rdE = 5'($urandom_range(0, 3));
      rs1D = 5'($urandom_range(0, 3));
      rs2D = 5'($urandom_range(0, 3));
      use_rs1D = 1'($urandom_range(0, 1));
      use_rs2D = 1'($urandom_range(0, 1));
      reg_writeE = $urandom_range(0, 3) != 0;
      mem_loadE = $urandom_range(0, 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      #1;
      luh = reg_writeE && mem_loadE != 0 && rdE != 0 &&
            ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
      mw = mem_reqM && !mem_ready;
      for (int i = 0; i < 2; i++) begin
        e_st = 0; e_fl = 0; e_fr = 0;
        if (!RST) begin
          if (mw) begin
            e_fr = 1; e_st = owed[i] > 0;
          end else if (fail_predictE) e_fl = 1;
          else if (owed[i] > 0 || luh) e_st = 1;
        end
        chk(i == 0 ? "outs_lat3" : "outs_lat1", 32'(ob[i*6 +: 6]),
            RST ? 32'd0 : 32'({e_st, e_st, e_fl, e_fr, err[i], owed[i] > 0}));
`ifdef HAZ_PERF_EN
        for (int k = 0; k < 3; k++) chk($sformatf("perf%0d_u%0d", k, i), pb[(i*3+k)*32 +: 32], pc[i][k]);
`endif
        if (RST) begin
          owed[i] = 0; frz_run[i] = 0; err[i] = 0;
          for (int k = 0; k < 3; k++) pc[i][k] = 0;
        end else begin
          if (!mw) begin
            if (fail_predictE) owed[i] = 0;
            else if (owed[i] > 0) owed[i]--;
            else if (luh) owed[i] = lat[i] - 1;
          end
          if (e_fr) begin
            if (frz_run[i] == tmo[i] - 1) err[i] = 1;
            if (frz_run[i] < 255) frz_run[i]++;
          end else frz_run[i] = 0;
          pc[i][0] += 32'(e_st);
          pc[i][1] += 32'(e_fl);
          pc[i][2] += 32'(e_fr);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
